obi_copy_master: RTL and testbench
==================================

Name: obi_copy_master

Overview:
- Bus initiator that copies a block of 32-bit words from a source address range to a destination address range.
- Uses the data_req/data_gnt/data_rvalid request-response protocol that the peripheral block answers.
- Sits beside the core as a second initiator, for memory-to-memory and memory-to-GPIO transfers.
- Issues exactly one outstanding transaction at a time: read word, then write word, repeat.

Parameters:
- LEN_WIDTH, 16, width of the word-count field; the maximum transfer is 2^LEN_WIDTH-1 words.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous active-low reset; all state clears immediately while low
- start  input  1  one-cycle request to begin a copy; honoured only in IDLE
- src_addr  input  32  source byte address, sampled on accepted start; bits[1:0] ignored
- dst_addr  input  32  destination byte address, sampled on accepted start; bits[1:0] ignored
- xfer_len  input  LEN_WIDTH  number of words to copy, sampled on accepted start
- busy  output  1  high from the cycle after an accepted start until DONE exits
- done  output  1  one-cycle pulse when a copy completes or aborts
- error  output  1  sticky abort flag; cleared on the next accepted start
- words_done  output  LEN_WIDTH  count of words written successfully in the current or last copy
- data_req  output  1  bus request
- data_we  output  1  1 = write, 0 = read
- data_be  output  4  byte enables; always 4'b1111 when data_req is high
- data_addr  output  32  word-aligned address, bits[1:0] = 2'b00
- data_wdata  output  32  write data
- data_gnt  input  1  responder accepted the request this cycle
- data_rvalid  input  1  response valid
- data_rdata  input  32  read data, valid with data_rvalid
- data_err  input  1  response error, valid with data_rvalid

Behaviour:
- Reset values: data_req=0, data_we=0, data_be=0, data_addr=0, data_wdata=0, busy=0, done=0, error=0, words_done=0, state=IDLE.
- Handshake rules:
  - Once data_req is raised, data_req, data_we, data_be, data_addr and data_wdata hold stable until the cycle data_gnt=1.
  - data_req drops in the cycle after grant.
  - The block waits for data_rvalid, arriving one or more cycles after gnt, before issuing the next request.
  - data_gnt and data_rvalid in the same cycle as the request's own gnt are not expected; a late rvalid is tolerated with any delay.
- State machine:
  - IDLE: start=1 with xfer_len=0 goes to DONE. start=1 with xfer_len>0 latches src&~3, dst&~3 and len, clears words_done and error, then goes to RD_REQ.
  - RD_REQ: data_req=1, data_we=0, data_addr=src_ptr. On gnt, go to RD_WAIT.
  - RD_WAIT: on rvalid with err=0, capture data_rdata into the write-data register and go to WR_REQ. On rvalid with err=1, set error and go to DONE.
  - WR_REQ: data_req=1, data_we=1, data_addr=dst_ptr, data_wdata=captured word. On gnt, go to WR_WAIT.
  - WR_WAIT: on rvalid with err=1, set error and go to DONE. On rvalid with err=0: src_ptr+=4, dst_ptr+=4, words_done+=1, remaining-=1. If remaining becomes 0 go to DONE, else go to RD_REQ.
  - DONE: done=1 for exactly one cycle, then IDLE.
- Latency: the minimum per-word time is 4 cycles with zero-wait gnt and rvalid one cycle after gnt.
- Address pointers are 32-bit and wrap modulo 2^32 (0xFFFFFFFC+4 = 0x00000000) with no error.
- start while busy is ignored; the inputs are not re-sampled.
- Reset asserted mid-transfer aborts immediately:
  - data_req drops asynchronously.
  - Any pending rvalid after reset release is ignored in IDLE.
- rvalid received in IDLE, RD_REQ, WR_REQ or DONE is ignored.
- words_done holds its final value after DONE until the next accepted start.

Test Plan:
1. Copy of 3 words, src=0x100, dst=0x200, zero-wait responder returning 0xA0,0xA1,0xA2 -> writes 0x200=0xA0, 0x204=0xA1, 0x208=0xA2 in order; done pulses once; words_done=3; error=0; 12 cycles from the first req to done.
2. Responder delays gnt by 3 cycles and rvalid by 2 cycles -> data_addr, data_we and data_wdata stay stable throughout the wait; no second req before rvalid; copy completes correctly.
3. xfer_len=0 -> no data_req ever; done pulses the cycle after start; busy stays 0.
4. data_err=1 on the second write of a 4-word copy -> error=1, words_done=1, done pulses, no further requests; the next start clears error.
5. src=0xFFFFFFFC, dst=0x00000013, len=2 -> reads 0xFFFFFFFC then 0x00000000; writes 0x00000010 then 0x00000014.
6. rst driven low while in WR_REQ -> data_req=0 in the same cycle; after release: IDLE, busy=0, and a stray rvalid is ignored.

Source files
------------

// File: rtl/obi_copy_master_if.sv
// Request/response bus between the copy initiator and a memory-style responder.
// The master drives the request channel; the slave answers with grant and response.
interface obi_copy_master_if;
    logic        data_req;
    logic        data_we;
    logic [3:0]  data_be;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_gnt;
    logic        data_rvalid;
    logic [31:0] data_rdata;
    logic        data_err;

    modport master (
        output data_req, data_we, data_be, data_addr, data_wdata,
        input  data_gnt, data_rvalid, data_rdata, data_err
    );

    modport slave (
        input  data_req, data_we, data_be, data_addr, data_wdata,
        output data_gnt, data_rvalid, data_rdata, data_err
    );
endinterface

// File: rtl/obi_copy_master.sv
// Block-copy bus initiator: reads one word, writes it back elsewhere, repeats.
// Exactly one transaction is in flight at any time.
module obi_copy_master #(
    parameter int LEN_WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 start_i,
    input  logic [31:0]          src_addr_i,
    input  logic [31:0]          dst_addr_i,
    input  logic [LEN_WIDTH-1:0] xfer_len_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 error_o,
    output logic [LEN_WIDTH-1:0] words_done_o,
    obi_copy_master_if.master    bus
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_REQ  = 3'd1,
        RD_WAIT = 3'd2,
        WR_REQ  = 3'd3,
        WR_WAIT = 3'd4,
        DONE    = 3'd5
    } state_e;

    state_e               state_q, state_d;
    logic [31:0]          src_q, src_d;
    logic [31:0]          dst_q, dst_d;
    logic [31:0]          wdata_q, wdata_d;
    logic [LEN_WIDTH-1:0] rem_q, rem_d;
    logic [LEN_WIDTH-1:0] cnt_q, cnt_d;
    logic                 err_q, err_d;
    logic                 busy_q, busy_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            wdata_q <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            wdata_q <= wdata_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        wdata_d = wdata_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        busy_d  = busy_q;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    err_d = 1'b0;
                    cnt_d = '0;
                    if (xfer_len_i == '0) begin
                        // Empty copy completes without touching the bus or raising busy.
                        state_d = DONE;
                    end else begin
                        src_d   = {src_addr_i[31:2], 2'b00};
                        dst_d   = {dst_addr_i[31:2], 2'b00};
                        rem_d   = xfer_len_i;
                        busy_d  = 1'b1;
                        state_d = RD_REQ;
                    end
                end
            end
            RD_REQ: begin
                if (bus.data_gnt) state_d = RD_WAIT;
            end
            RD_WAIT: begin
                if (bus.data_rvalid) begin
                    if (bus.data_err) begin
                        err_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        wdata_d = bus.data_rdata;
                        state_d = WR_REQ;
                    end
                end
            end
            WR_REQ: begin
                if (bus.data_gnt) state_d = WR_WAIT;
            end
            WR_WAIT: begin
                if (bus.data_rvalid) begin
                    if (bus.data_err) begin
                        err_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        // Pointers wrap modulo 2^32 by plain 32-bit addition.
                        src_d   = src_q + 32'd4;
                        dst_d   = dst_q + 32'd4;
                        cnt_d   = cnt_q + LEN_WIDTH'(1);
                        rem_d   = rem_q - LEN_WIDTH'(1);
                        state_d = (rem_q == LEN_WIDTH'(1)) ? DONE : RD_REQ;
                    end
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Request outputs decode straight from state so reset drops them asynchronously
    // and they stay frozen for as long as the request waits for grant.
    logic rd_req, wr_req;
    assign rd_req = (state_q == RD_REQ);
    assign wr_req = (state_q == WR_REQ);

    assign bus.data_req   = rd_req | wr_req;
    assign bus.data_we    = wr_req;
    assign bus.data_be    = (rd_req | wr_req) ? 4'hF : 4'h0;
    assign bus.data_addr  = rd_req ? src_q : (wr_req ? dst_q : 32'h0);
    assign bus.data_wdata = wr_req ? wdata_q : 32'h0;

    assign busy_o       = busy_q;
    assign done_o       = (state_q == DONE);
    assign error_o      = err_q;
    assign words_done_o = cnt_q;

endmodule

// File: tb/tb_obi_copy_master.sv
// Directed and randomized copies against a memory responder; every write is
// compared with the word the reference copy rule predicts.
module tb_obi_copy_master;
    localparam int LW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [31:0]   src = '0;
    logic [31:0]   dst = '0;
    logic [LW-1:0] len = '0;
    logic          busy, done, error;
    logic [LW-1:0] words_done;

    obi_copy_master_if bus();

    obi_copy_master #(.LEN_WIDTH(LW)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .start_i      (start),
        .src_addr_i   (src),
        .dst_addr_i   (dst),
        .xfer_len_i   (len),
        .busy_o       (busy),
        .done_o       (done),
        .error_o      (error),
        .words_done_o (words_done),
        .bus          (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [logic [31:0]];
    logic [31:0] rd_log[$];
    logic [31:0] wr_addr_log[$];
    logic [31:0] wr_data_log[$];
    int gnt_dly = 0;
    int rv_dly  = 0;
    int err_wr  = -1;
    int wr_seen = 0;
    bit resp_en = 1'b1;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rd_word(logic [31:0] a);
        if (!mem.exists(a)) mem[a] = $urandom;
        return mem[a];
    endfunction

    // Memory responder: grant after gnt_dly waiting cycles, respond rv_dly cycles later.
    task automatic responder();
        bit          pend = 1'b0, pend_err = 1'b0, waiting = 1'b0;
        int          pcnt = 0, wcnt = 0;
        logic [31:0] pdata = '0, a0 = '0, d0 = '0;
        logic        we0 = 1'b0;
        forever begin
            @(negedge clk);
            if (!resp_en) begin
                pend = 1'b0; waiting = 1'b0; wcnt = 0;
                continue;
            end
            bus.data_gnt = 1'b0; bus.data_rvalid = 1'b0;
            bus.data_err = 1'b0; bus.data_rdata = '0;
            if (!rst_n) begin
                pend = 1'b0; waiting = 1'b0; wcnt = 0;
                continue;
            end
            if (pend) begin
                chk("no_req_while_pending", 32'(bus.data_req), 32'd0);
                if (pcnt == 0) begin
                    bus.data_rvalid = 1'b1;
                    bus.data_rdata  = pdata;
                    bus.data_err    = pend_err;
                    pend = 1'b0;
                end else pcnt--;
            end else if (bus.data_req) begin
                if (!waiting) begin
                    waiting = 1'b1; wcnt = 0;
                    a0 = bus.data_addr; d0 = bus.data_wdata; we0 = bus.data_we;
                end else begin
                    chk("hold_addr", bus.data_addr, a0);
                    chk("hold_we", 32'(bus.data_we), 32'(we0));
                    chk("hold_wdata", bus.data_wdata, d0);
                end
                chk("be_full", 32'(bus.data_be), 32'hF);
                if (wcnt >= gnt_dly) begin
                    bus.data_gnt = 1'b1;
                    waiting = 1'b0; pend = 1'b1; pcnt = rv_dly; pend_err = 1'b0;
                    if (bus.data_we) begin
                        wr_addr_log.push_back(bus.data_addr);
                        wr_data_log.push_back(bus.data_wdata);
                        pend_err = (wr_seen == err_wr);
                        wr_seen++;
                        pdata = '0;
                    end else begin
                        rd_log.push_back(bus.data_addr);
                        pdata = rd_word(bus.data_addr);
                    end
                end else wcnt++;
            end
        end
    endtask

    // One copy: expected traffic is word i read from src+4i and written to dst+4i,
    // stopping after the failing write when ew selects one.
    task automatic run_copy(logic [31:0] s, logic [31:0] d, int n, int gd, int rd, int ew, int exp_cyc);
        int nfirst = -1, ndone = -1, ndone_cnt = 0, nreq_after = 0, nw, exp_wd;
        bit saw_busy = 1'b0, exp_err;
        logic [31:0] sa, da;
        gnt_dly = gd; rv_dly = rd; err_wr = ew; wr_seen = 0;
        rd_log.delete(); wr_addr_log.delete(); wr_data_log.delete();
        src = s; dst = d; len = LW'(n); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("error_cleared_on_start", 32'(error), 32'd0);
        for (int k = 0; k < 4000; k++) begin
            if (busy) saw_busy = 1'b1;
            if (bus.data_req && nfirst < 0) nfirst = k;
            if (done) begin
                ndone = k;
                break;
            end
            @(negedge clk);
        end
        chk("done_seen", 32'(ndone >= 0), 32'd1);
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            if (done) ndone_cnt++;
            if (bus.data_req) nreq_after++;
        end
        chk("done_single_pulse", ndone_cnt, 0);
        chk("no_req_after_done", nreq_after, 0);
        chk("busy_after_done", 32'(busy), 32'd0);

        exp_err = (ew >= 0 && ew < n);
        nw      = exp_err ? ew + 1 : n;
        exp_wd  = exp_err ? ew : n;
        chk("words_done", 32'(words_done), exp_wd);
        chk("error_flag", 32'(error), 32'(exp_err));
        chk("n_reads", rd_log.size(), nw);
        chk("n_writes", wr_addr_log.size(), nw);
        chk("busy_seen", 32'(saw_busy), 32'(n > 0));
        if (n == 0) begin
            chk("no_req_for_empty", nfirst, -1);
            chk("empty_done_next_cycle", ndone, 0);
        end else begin
            chk("req_cycle_after_start", nfirst, 0);
        end
        if (exp_cyc > 0) chk("latency_first_req_to_done", ndone - nfirst, exp_cyc);
        sa = {s[31:2], 2'b00};
        da = {d[31:2], 2'b00};
        for (int i = 0; i < nw && i < rd_log.size() && i < wr_addr_log.size(); i++) begin
            chk("rd_addr", rd_log[i], sa + 32'(4 * i));
            chk("wr_addr", wr_addr_log[i], da + 32'(4 * i));
            chk("wr_data", wr_data_log[i], rd_word(sa + 32'(4 * i)));
        end
    endtask

    initial begin
        bus.data_gnt = 1'b0; bus.data_rvalid = 1'b0;
        bus.data_err = 1'b0; bus.data_rdata = '0;
        fork responder(); join_none

        #1;
        chk("rst_req", 32'(bus.data_req), 32'd0);
        chk("rst_we", 32'(bus.data_we), 32'd0);
        chk("rst_be", 32'(bus.data_be), 32'd0);
        chk("rst_addr", bus.data_addr, 32'd0);
        chk("rst_wdata", bus.data_wdata, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        chk("rst_words_done", 32'(words_done), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Zero-wait three-word copy with known data and 12-cycle span.
        mem[32'h100] = 32'hA0; mem[32'h104] = 32'hA1; mem[32'h108] = 32'hA2;
        run_copy(32'h100, 32'h200, 3, 0, 0, -1, 12);
        if (wr_data_log.size() == 3) begin
            chk("t1_w0", wr_data_log[0], 32'hA0);
            chk("t1_w2", wr_data_log[2], 32'hA2);
            chk("t1_a2", wr_addr_log[2], 32'h208);
        end

        // Slow responder: requests must hold steady while waiting.
        run_copy(32'h500, 32'h600, 3, 3, 2, -1, 0);

        // Empty copy.
        run_copy(32'h700, 32'h800, 0, 0, 0, -1, 0);

        // Error on the second write of four.
        run_copy(32'h1000, 32'h2000, 4, 0, 0, 1, 0);

        // Address wrap; also proves the previous error got cleared by start.
        run_copy(32'hFFFF_FFFC, 32'h0000_0013, 2, 0, 0, -1, 0);
        if (rd_log.size() == 2 && wr_addr_log.size() == 2) begin
            chk("wrap_rd0", rd_log[0], 32'hFFFF_FFFC);
            chk("wrap_rd1", rd_log[1], 32'h0000_0000);
            chk("wrap_wr0", wr_addr_log[0], 32'h0000_0010);
            chk("wrap_wr1", wr_addr_log[1], 32'h0000_0014);
        end

        // Reset while a write request is waiting for grant.
        gnt_dly = 8; rv_dly = 0; err_wr = -1; wr_seen = 0;
        src = 32'h300; dst = 32'h400; len = LW'(2); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (bus.data_req && bus.data_we) break;
            @(negedge clk);
        end
        chk("reached_wr_req", 32'(bus.data_req && bus.data_we), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("arst_req", 32'(bus.data_req), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_addr", bus.data_addr, 32'd0);
        @(negedge clk);
        resp_en = 1'b0;
        bus.data_gnt = 1'b0; bus.data_rvalid = 1'b0; bus.data_err = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        bus.data_rvalid = 1'b1; bus.data_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        bus.data_rvalid = 1'b0;
        for (int j = 0; j < 3; j++) begin
            chk("stray_rvalid_req", 32'(bus.data_req), 32'd0);
            chk("stray_rvalid_busy", 32'(busy), 32'd0);
            chk("stray_rvalid_done", 32'(done), 32'd0);
            @(negedge clk);
        end
        chk("post_rst_words_done", 32'(words_done), 32'd0);
        resp_en = 1'b1;

        // Randomized copies with random delays and occasional write errors.
        for (int it = 0; it < 10; it++) begin
            int n, ew;
            n  = $urandom_range(1, 6);
            ew = ($urandom_range(0, 3) == 0) ? $urandom_range(0, n - 1) : -1;
            run_copy($urandom, $urandom, n, $urandom_range(0, 3), $urandom_range(0, 3), ew, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
